// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory arbiter slice.
//   owner_e        : which port owns the response returning next cycle.
//   CONFLICT_CNT_W : width of the saturating conflict counter.
package mem_arb_pkg;

   localparam int CONFLICT_CNT_W = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Two-request picker for the memory arbiter. Grants are purely
//   combinational from the request lines.
//   Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   : conflicts alternate between ports; a 1-bit pointer
//                 (reset to fetch-preferred) moves only on conflict cycles.
//     undefined : fixed priority, data port wins; no state, no clock.
//   Ports:
//     clk, reset_ni : clock / async active-low reset (round-robin build only)
//     i_req, d_req  : fetch / data requests
//     i_gnt, d_gnt  : one-hot-or-zero grants
module mem_arb_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset_ni,
`endif
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic prefer_i;
   logic conflict;

   assign conflict = i_req & d_req;

   // The pointer names the port that wins the next conflict; after a
   // conflict the loser becomes preferred, so it simply toggles.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         prefer_i <= 1'b1;
      end else if (conflict) begin
         prefer_i <= ~prefer_i;
      end
   end

   always_comb begin
      i_gnt = i_req & (~d_req |  prefer_i);
      d_gnt = d_req & (~i_req | ~prefer_i);
   end
`else
   always_comb begin
      d_gnt = d_req;
      i_gnt = i_req & ~d_req;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous memory (1-cycle read latency)
//   between an instruction-fetch port and a data port.
//   Configuration macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on conflicts;
//   default build uses fixed data-over-fetch priority).
//   Ports:
//     clk, reset_ni          : clock / async active-low reset
//     i_req_i, i_addr_i      : fetch request and word address
//     i_gnt_o                : fetch granted this cycle
//     i_rvalid_o, i_rdata_o  : fetch response (one cycle after grant)
//     d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i : data request/attributes
//     d_gnt_o                : data granted this cycle
//     d_rvalid_o, d_rdata_o  : data response / write acknowledge
//     mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o : memory drive
//     mem_rdata_i            : memory read data, one cycle after mem_en_o
//     conflict_cnt_o         : saturating count of both-requesting cycles
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      reset_ni,
   input  logic                      i_req_i,
   input  logic [ADDR_W-1:0]         i_addr_i,
   output logic                      i_gnt_o,
   output logic                      i_rvalid_o,
   output logic [DATA_W-1:0]         i_rdata_o,
   input  logic                      d_req_i,
   input  logic                      d_we_i,
   input  logic [DATA_W/8-1:0]       d_be_i,
   input  logic [ADDR_W-1:0]         d_addr_i,
   input  logic [DATA_W-1:0]         d_wdata_i,
   output logic                      d_gnt_o,
   output logic                      d_rvalid_o,
   output logic [DATA_W-1:0]         d_rdata_o,
   output logic                      mem_en_o,
   output logic                      mem_we_o,
   output logic [DATA_W/8-1:0]       mem_be_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [DATA_W-1:0]         mem_wdata_o,
   input  logic [DATA_W-1:0]         mem_rdata_i,
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
);

   owner_e                    owner_p1;
   logic [CONFLICT_CNT_W-1:0] conflict_cnt_p1;

   function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(
      input logic [CONFLICT_CNT_W-1:0] v
   );
      return (&v) ? v : v + CONFLICT_CNT_W'(1);
   endfunction

   mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .clk      (clk),
      .reset_ni (reset_ni),
`endif
      .i_req    (i_req_i),
      .d_req    (d_req_i),
      .i_gnt    (i_gnt_o),
      .d_gnt    (d_gnt_o)
   );

   // Stage p0: winner's attributes drive the memory combinationally.
   always_comb begin
      mem_en_o    = i_gnt_o | d_gnt_o;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (d_gnt_o) begin
         mem_we_o    = d_we_i;
         mem_be_o    = d_be_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
      end else if (i_gnt_o) begin
         mem_be_o    = '1;
         mem_addr_o  = i_addr_i;
      end
   end

   // Stage p1: owner of the returning response and the conflict counter.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         owner_p1        <= OWN_NONE;
         conflict_cnt_p1 <= '0;
      end else begin
         if (d_gnt_o) begin
            owner_p1 <= OWN_D;
         end else if (i_gnt_o) begin
            owner_p1 <= OWN_I;
         end else begin
            owner_p1 <= OWN_NONE;
         end
         if (i_req_i && d_req_i) begin
            conflict_cnt_p1 <= sat_inc(conflict_cnt_p1);
         end
      end
   end

   // Read data fans out to both ports; rvalid qualifies it.
   assign i_rvalid_o     = (owner_p1 == OWN_I);
   assign d_rvalid_o     = (owner_p1 == OWN_D);
   assign i_rdata_o      = mem_rdata_i;
   assign d_rdata_o      = mem_rdata_i;
   assign conflict_cnt_o = conflict_cnt_p1;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between the processor's instruction-fetch port and data port. Each port uses a req/gnt/rvalid handshake. The arbiter grants at most one access per cycle and routes the one-cycle-latency read data back to the port that issued the access. It sits between the processor core and the `memory` array, so the core can move off a dual-ported memory model.

## Interface
- `ADDR_W`, default 30: word-address width.
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_ni` in 1: asynchronous active-low reset.
- `i_req_i` in 1: fetch request; held with its address until granted.
- `i_addr_i` in ADDR_W: fetch word address.
- `i_gnt_o` out 1: fetch granted this cycle.
- `i_rvalid_o` out 1: fetch data valid.
- `i_rdata_o` out DATA_W: fetch data.
- `d_req_i` in 1: data request; held with its attributes until granted.
- `d_we_i` in 1: 1 = write, 0 = read.
- `d_be_i` in DATA_W/8: byte enables for writes.
- `d_addr_i` in ADDR_W: data word address.
- `d_wdata_i` in DATA_W: write data.
- `d_gnt_o` out 1: data access granted.
- `d_rvalid_o` out 1: data response; read data valid, or write acknowledge.
- `d_rdata_o` out DATA_W: read data.
- `mem_en_o` out 1: memory access this cycle.
- `mem_we_o` out 1: memory write.
- `mem_be_o` out DATA_W/8: memory byte enables.
- `mem_addr_o` out ADDR_W: memory word address.
- `mem_wdata_o` out DATA_W: memory write data.
- `mem_rdata_i` in DATA_W: memory read data, valid one cycle after `mem_en_o`.
- `conflict_cnt_o` out 16: count of cycles in which both ports requested; saturating.

## Operation
- **Grant:** combinational, same cycle as the request. At most one of `i_gnt_o` / `d_gnt_o` is high, and a grant is only given to a requesting port.
- **Default priority:** fixed; the data port wins when both ports request.
- **Memory drive:** `mem_*_o` carry the winner's attributes combinationally.
  - Fetch winner: `mem_we_o` = 0 and `mem_be_o` = all-ones.
  - No winner: `mem_en_o` = 0 and `mem_we_o` = 0.
- **Owner register:** holds `OWN_NONE`, `OWN_I` or `OWN_D`. It loads the winner every cycle, or `OWN_NONE` when there is no grant.
- **Response:** `x_rvalid_o` = (owner == x), so exactly one pulse per grant, one cycle later.
  - Both `i_rdata_o` and `d_rdata_o` = `mem_rdata_i` and are meaningful only with their rvalid.
  - A write also produces `d_rvalid_o`; its rdata is don't-care.
- **Conflict counter:** increments by 1 on every cycle with `i_req_i` and `d_req_i` both high, and saturates at 0xFFFF.
- **Back-to-back:** a requester may issue a new request in the cycle its previous rvalid arrives, or earlier.
- **Reset mid-operation:** an outstanding response is discarded; no rvalid appears after reset deasserts.

## Timing
- Reset values:
  - all gnt and rvalid outputs = 0;
  - `mem_en_o` = 0 and `mem_we_o` = 0, since no port requests (the request inputs are forced low by the core during reset);
  - owner = `OWN_NONE`;
  - `conflict_cnt_o` = 0;
  - round-robin pointer = fetch-preferred.
- Grant latency: 0 cycles (combinational from req). Response latency: exactly 1 cycle after grant.
- Throughput: 1 access per cycle in aggregate.
- Losing port: waits with req held; its latency becomes 1 + number of cycles lost.
- No combinational path from `mem_rdata_i` to any gnt. The only combinational paths are req/attributes → gnt/mem outputs and `mem_rdata_i` → rdata.

## Configuration
- **`MEM_ARB_ROUND_ROBIN_EN` defined:**
  - On a conflict cycle, grant the port not granted on the most recent conflict.
  - A 1-bit pointer updates only on conflict cycles; uncontested grants do not move it.
  - The first conflict after reset goes to fetch.
- **`MEM_ARB_ROUND_ROBIN_EN` undefined:** fixed data-over-fetch priority, and no pointer flop.

## Structure
- Package `mem_arb_pkg`:
  - `owner_e` enum {`OWN_NONE`, `OWN_I`, `OWN_D`} (2 bits);
  - `CONFLICT_CNT_W` = 16.
- Sub-module `mem_arb_pick`: 2-request picker that contains the priority/round-robin logic and the pointer flop. Its outputs are the two grant lines.
- Top module contains the memory muxing, the owner register and the counter.

## Test plan
- Fetch only: `i_req_i` = 1 at addr 0x10 with memory word 0x13 → `i_gnt_o` = 1 same cycle; next cycle `i_rvalid_o` = 1, `i_rdata_o` = 0x13, `d_rvalid_o` = 0.
- Data write then read, addr 0x20:
  - write `d_wdata_i` = 0xDEADBEEF, `d_be_i` = 0xF → `mem_we_o` = 1, `d_rvalid_o` next cycle;
  - read of 0x20 → `d_rdata_o` = 0xDEADBEEF.
- Conflict, fixed priority: both request for 3 cycles → `d_gnt_o` = 1 each cycle, `i_gnt_o` = 0; `conflict_cnt_o` = 3; fetch granted in the first cycle after `d_req_i` drops.
- Conflict, round-robin build: both held requesting for 4 cycles → grants alternate I, D, I, D; each rvalid goes to the correct port the following cycle.
- Reset mid-operation: assert `reset_ni` = 0 asynchronously the cycle after a data grant → `d_rvalid_o` = 0 immediately and stays 0 after release; `conflict_cnt_o` = 0.
- Saturation: force 0x10000 conflict cycles → `conflict_cnt_o` holds 0xFFFF.
